// File: rtl/bus_memory.sv
// Tagged main memory on the CPU external bus: address strobe, 64-bit data + 8-bit tag, per-page write protection.
// Optional sticky error interrupt is built only when BUS_ERR_IRQ_EN is defined.
module bus_memory #(
    parameter int          ADDR_W    = 14,
    parameter int          PAGE_W    = 10,
    parameter logic [19:0] CTRL_ADDR = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ad,
    input  logic [7:0]  tag_in,
    input  logic        astb,
    input  logic        rd,
    input  logic        wr,
    input  logic        wforce,
    input  logic        iack,
    output logic [63:0] rdata,
    output logic [7:0]  rtag,
    output logic        irq,
    output logic        prot_err,
    output logic        bus_err
);
    localparam int MASK_W = 2 ** (ADDR_W - PAGE_W);

    typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} state_t;

    state_t             state, state_next;
    logic [19:0]        addr;
    logic [MASK_W-1:0]  mask;
    logic [71:0]        mem [2**ADDR_W];

    logic in_range, is_ctrl, page_locked;
    logic do_read, do_mem_wr, do_mask_wr, rej_prot, rej_range, proto_err;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (astb) state_next = ADDR;
    end

    // Address register carries no reset: an invalid address is tracked by the FSM alone.
    always_ff @(posedge clk) begin
        if (astb) addr <= ad[19:0];
    end

    // Stage p0: decode the bus request against the latched address
    always_comb begin
        in_range    = (addr[19:ADDR_W] == '0);
        is_ctrl     = (addr == CTRL_ADDR);
        page_locked = mask[addr[ADDR_W-1:PAGE_W]];
        proto_err   = (rd || wr) && (state == IDLE || astb || (rd && wr));
        do_read     = 1'b0;
        do_mem_wr   = 1'b0;
        do_mask_wr  = 1'b0;
        rej_prot    = 1'b0;
        rej_range   = 1'b0;
        if (state == ADDR && !astb && (rd ^ wr)) begin
            if (rd) begin
                do_read   = 1'b1;
                rej_range = !is_ctrl && !in_range;
            end else if (is_ctrl) begin
                do_mask_wr = wforce;
                rej_prot   = !wforce;
            end else if (!in_range) begin
                rej_range = 1'b1;
            end else if (page_locked && !wforce) begin
                rej_prot = 1'b1;
            end else begin
                do_mem_wr = 1'b1;
            end
        end
    end

    // Stage p1: registered read data, mask update and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rtag     <= '0;
            prot_err <= 1'b0;
            bus_err  <= 1'b0;
            mask     <= '0;
        end else begin
            prot_err <= rej_prot;
            bus_err  <= proto_err || rej_range;
            if (do_mask_wr) mask <= ad[MASK_W-1:0];
            if (do_read) begin
                if (is_ctrl)       {rtag, rdata} <= {8'h00, {(64-MASK_W){1'b0}}, mask};
                else if (in_range) {rtag, rdata} <= mem[addr[ADDR_W-1:0]];
                else               {rtag, rdata} <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_mem_wr && !reset) mem[addr[ADDR_W-1:0]] <= {tag_in, ad};
    end

`ifdef BUS_ERR_IRQ_EN
    logic irq_flag;

    // Sticky: a pulse visible this cycle wins over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (reset) irq_flag <= 1'b0;
        else       irq_flag <= prot_err || bus_err || (irq_flag && !iack);
    end

    assign irq = irq_flag;
`else
    logic unused_iack;
    assign unused_iack = iack;
    assign irq         = 1'b0;
`endif

endmodule

// File: doc/bus_memory.md
Name: bus_memory

Overview:
Tagged main-memory responder on the CPU external bus; consumes the CPU's address/data, strobe and read/write outputs and produces the data and tag the CPU reads back.
- Latches a physical address on the address strobe, then services reads and writes of 64-bit words with 8-bit tags.
- Enforces per-page write protection, which the write-force input overrides.
- Used by CPU-level benches and by the top-level system in place of the test benches' ad-hoc memory models.

Parameters:
ADDR_W, 14, word address width of backing store (depth 2**ADDR_W words)
PAGE_W, 10, log2 of page size in words; protection granularity
CTRL_ADDR, 20'hFFFFF, physical address of the protection-mask control word

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
ad  input  64  CPU o_ad: address in bits [19:0] on strobe cycle; write data on write cycle
tag_in  input  8  CPU o_tag: tag written with data
astb  input  1  address strobe
rd  input  1  read request
wr  input  1  write request
wforce  input  1  write ignores page protection
iack  input  1  interrupt acknowledge from CPU
rdata  output  64  read data to CPU i_data
rtag  output  8  read tag to CPU i_tag
irq  output  1  interrupt request to CPU i_irq
prot_err  output  1  one-cycle pulse: write rejected by protection
bus_err  output  1  one-cycle pulse: protocol or range error

Behaviour:
- Reset: rdata=0, rtag=0, irq=0, prot_err=0, bus_err=0, protection mask=0 (all pages writable), address invalid, FSM=IDLE. Memory contents are not cleared.
- FSM states:
  - IDLE: no valid address.
  - ADDR: address latched.
  - Transitions: astb in any state -> ADDR, addr <= ad[19:0]. ADDR stays ADDR across any number of rd/wr cycles, so read-modify-write at one address is legal.
- Read: rd=1 in ADDR, astb=0, wr=0.
  - At that edge, rdata/rtag <= mem[addr]. Visible from the next cycle (latency 1).
  - rdata/rtag hold until the next accepted read.
- Write: wr=1 in ADDR, astb=0, rd=0.
  - At that edge, mem[addr] <= {tag_in, ad} unless rejected.
  - A read issued the following cycle returns the new value.
- Protection:
  - Page index p = addr[ADDR_W-1:PAGE_W]; mask has 2**(ADDR_W-PAGE_W) bits.
  - Write to a page with mask[p]=1 and wforce=0: memory unchanged; prot_err=1 for one cycle.
- Control word at addr==CTRL_ADDR:
  - Write requires wforce=1; sets mask <= ad[mask width-1:0]. Without wforce: rejected with prot_err.
  - Read returns {zero-extend mask} with rtag=0.
- Range: addr >= 2**ADDR_W and not CTRL_ADDR.
  - Read returns rdata=0, rtag=0.
  - Write is dropped.
  - bus_err pulses.
- Protocol errors (bus_err pulse, no memory change, rdata/rtag unchanged):
  - rd or wr in IDLE.
  - rd and wr both high.
  - rd or wr in the same cycle as astb (astb still latches the address).
- Errors never change FSM state except as astb dictates.
- irq is 0 unless BUS_ERR_IRQ_EN is defined.
- Reset asserted mid-sequence: on the next edge the FSM returns to IDLE and the address is discarded. A following rd without astb is a protocol error.

Optional Feature:
BUS_ERR_IRQ_EN
- Defined: irq is set on the cycle after any prot_err or bus_err pulse and stays high (sticky) until iack=1 at an edge, which clears it.
  - A new error in the same cycle as iack keeps irq high.
  - Reset clears irq.
- Undefined: irq is tied to 0, iack is ignored, and no sticky flag is built.

Test Plan:
1. astb ad=20'h00010, then wr ad=64'h0123456789ABCDEF tag_in=8'h3A; astb ad=20'h00010, rd -> next cycle rdata=64'h0123456789ABCDEF, rtag=8'h3A; no error pulses.
2. Write control word 64'h2 with wforce=1; write 64'h55 to addr 20'h00400 with wforce=0 -> prot_err one cycle, read returns old value. Repeat write with wforce=1 -> read returns 64'h55.
3. Write control word with wforce=0 -> prot_err, mask unchanged; read CTRL_ADDR returns 64'h2, rtag=0.
4. After reset, rd with no astb -> bus_err one cycle, rdata=0. astb and rd in the same cycle -> bus_err, and a subsequent rd reads the newly latched address.
5. astb ad=20'h08000 (out of range for ADDR_W=14), rd -> rdata=0, rtag=0, bus_err. wr -> bus_err, memory unchanged.
6. With BUS_ERR_IRQ_EN defined: trigger prot_err -> irq=1 the next cycle and held. iack=1 one cycle -> irq=0. Error in the same cycle as iack -> irq stays 1.
